// File: rtl/gate_truth_sweeper.sv
// Self-test sweeper for the elementary-gate library. It drives every input vector
// into a combinational gate, waits a settle delay, samples the output and checks it
// against a truth table.
`timescale 1ns/1ps

module gate_truth_sweeper #(
    parameter int                        N_INPUTS      = 2,
    parameter int                        SETTLE_CYCLES = 2,
    parameter logic [(2**N_INPUTS)-1:0]  EXPECTED      = 4'b0111
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [N_INPUTS-1:0]   dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_INPUTS-1:0]   fail_index,
    output logic [N_INPUTS:0]     fail_count
);

    localparam int N_VEC = 2**N_INPUTS;
    localparam logic [N_INPUTS-1:0] LAST_IDX = N_INPUTS'(N_VEC - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_settle_cnt;
    logic [N_INPUTS-1:0]  r_index;
    logic [N_INPUTS-1:0]  r_dut_in;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [N_INPUTS-1:0]  r_fail_index;
    logic [N_INPUTS:0]    r_fail_count;

    logic                 w_mismatch;
    logic                 w_last;

    // dut_out comes from a combinational gate in this clock domain, so it is used directly.
    assign w_mismatch = (dut_out != EXPECTED[r_index]);
    assign w_last     = (r_index == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples the values present before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default comes first, so every path assigns w_next_state and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next_state = S_DRIVE;
            end
            S_DRIVE: begin
                w_next_state = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                if (r_settle_cnt <= 4'd1) w_next_state = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_next_state = w_last ? S_DONE : S_DRIVE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= '0;
            r_index      <= '0;
            r_dut_in     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_index <= '0;
            r_fail_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_index      <= '0;
                        r_dut_in     <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_fail_index <= '0;
                        r_fail_count <= '0;
                    end
                end
                S_DRIVE: begin
                    r_settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    if (w_mismatch) begin
                        r_fail_count <= r_fail_count + 1'b1;
                        if (r_fail_count == '0) r_fail_index <= r_index;
                    end
                    if (w_last) begin
                        // The last vector's comparison is folded into pass on the same edge.
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_pass   <= (r_fail_count == '0) && !w_mismatch;
                        r_dut_in <= '0;
                    end else begin
                        r_index  <= r_index + 1'b1;
                        r_dut_in <= r_index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in     = r_dut_in;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_index = r_fail_index;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Scoreboard bench for gate_truth_sweeper covering the inverter, NAND and zero-settle
// configurations. Stimulus pushes expected results, and per-instance monitors check each done pulse.
`timescale 1ns/1ps

module tb_gate_truth_sweeper;

    typedef struct {
        logic       pass;
        logic [3:0] idx;
        logic [4:0] cnt;
        int         lat;
        int         start_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   edge_cnt = 0;
    int   tests = 0;
    int   failures = 0;

    exp_t q_inv[$];
    exp_t q_nand[$];
    exp_t q_s0[$];

    // Inverter instance: N_INPUTS=1, EXPECTED=2'b01, SETTLE_CYCLES=2.
    logic       inv_start = 1'b0;
    logic [0:0] inv_dut_in;
    logic       inv_out, inv_busy, inv_done, inv_pass;
    logic [0:0] inv_fail_index;
    logic [1:0] inv_fail_count;

    // Default NAND instance; the gate model is chosen by nand_mode.
    logic       nand_start = 1'b0;
    int         nand_mode = 2;
    logic [1:0] nand_dut_in;
    logic       nand_out, nand_busy, nand_done, nand_pass;
    logic [1:0] nand_fail_index;
    logic [2:0] nand_fail_count;

    // Zero-settle NAND instance.
    logic       s0_start = 1'b0;
    logic [1:0] s0_dut_in;
    logic       s0_out, s0_busy, s0_done, s0_pass;
    logic [1:0] s0_fail_index;
    logic [2:0] s0_fail_count;

    assign inv_out  = ~inv_dut_in[0];
    assign nand_out = (nand_mode == 0) ? 1'b0 : (nand_mode == 1) ? 1'b1 : ~&nand_dut_in;
    assign s0_out   = ~&s0_dut_in;

    gate_truth_sweeper #(.N_INPUTS(1), .SETTLE_CYCLES(2), .EXPECTED(2'b01)) u_inv (
        .clk(clk), .reset(reset), .start(inv_start), .dut_in(inv_dut_in), .dut_out(inv_out),
        .busy(inv_busy), .done(inv_done), .pass(inv_pass),
        .fail_index(inv_fail_index), .fail_count(inv_fail_count));

    gate_truth_sweeper #(.N_INPUTS(2), .SETTLE_CYCLES(2), .EXPECTED(4'b0111)) u_nand (
        .clk(clk), .reset(reset), .start(nand_start), .dut_in(nand_dut_in), .dut_out(nand_out),
        .busy(nand_busy), .done(nand_done), .pass(nand_pass),
        .fail_index(nand_fail_index), .fail_count(nand_fail_count));

    gate_truth_sweeper #(.N_INPUTS(2), .SETTLE_CYCLES(0), .EXPECTED(4'b0111)) u_s0 (
        .clk(clk), .reset(reset), .start(s0_start), .dut_in(s0_dut_in), .dut_out(s0_out),
        .busy(s0_busy), .done(s0_done), .pass(s0_pass),
        .fail_index(s0_fail_index), .fail_count(s0_fail_count));

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic p,
                                input logic [3:0] idx, input logic [4:0] cnt,
                                input logic b, input logic [3:0] din);
        check({tag, "_pass"}, 32'(p), 32'(e.pass));
        check({tag, "_fail_index"}, 32'(idx), 32'(e.idx));
        check({tag, "_fail_count"}, 32'(cnt), 32'(e.cnt));
        check({tag, "_latency"}, 32'(edge_cnt - e.start_edge), 32'(e.lat));
        check({tag, "_busy_low"}, 32'(b), 32'd0);
        check({tag, "_dut_in_zero"}, 32'(din), 32'd0);
    endtask

    // Monitors: one per instance, triggered by a rising done seen away from the clock edge.
    logic inv_done_q = 1'b0, nand_done_q = 1'b0, s0_done_q = 1'b0;

    always @(negedge clk) begin
        if (inv_done && !inv_done_q) begin
            if (q_inv.size() == 0) check("inv_unexpected_done", 32'd1, 32'd0);
            else check_result("inv", q_inv.pop_front(), inv_pass, 4'(inv_fail_index),
                              5'(inv_fail_count), inv_busy, 4'(inv_dut_in));
        end
        inv_done_q = inv_done;
    end

    always @(negedge clk) begin
        if (nand_done && !nand_done_q) begin
            if (q_nand.size() == 0) check("nand_unexpected_done", 32'd1, 32'd0);
            else check_result("nand", q_nand.pop_front(), nand_pass, 4'(nand_fail_index),
                              5'(nand_fail_count), nand_busy, 4'(nand_dut_in));
        end
        nand_done_q = nand_done;
    end

    always @(negedge clk) begin
        if (s0_done && !s0_done_q) begin
            if (q_s0.size() == 0) check("s0_unexpected_done", 32'd1, 32'd0);
            else check_result("s0", q_s0.pop_front(), s0_pass, 4'(s0_fail_index),
                              5'(s0_fail_count), s0_busy, 4'(s0_dut_in));
        end
        s0_done_q = s0_done;
    end

    // Pulse start on one instance for exactly one rising edge; returns at the negedge after it.
    task automatic drive_start(input int which);
        @(negedge clk);
        case (which)
            0: inv_start = 1'b1;
            1: nand_start = 1'b1;
            default: s0_start = 1'b1;
        endcase
        @(negedge clk);
        inv_start = 1'b0;
        nand_start = 1'b0;
        s0_start = 1'b0;
    endtask

    task automatic issue(input int which, input logic p, input logic [3:0] idx,
                         input logic [4:0] cnt, input int lat);
        exp_t e;
        e.pass = p;
        e.idx = idx;
        e.cnt = cnt;
        e.lat = lat;
        @(negedge clk);
        e.start_edge = edge_cnt + 1;
        case (which)
            0: begin q_inv.push_back(e);  inv_start = 1'b1;  end
            1: begin q_nand.push_back(e); nand_start = 1'b1; end
            default: begin q_s0.push_back(e); s0_start = 1'b1; end
        endcase
        @(negedge clk);
        inv_start = 1'b0;
        nand_start = 1'b0;
        s0_start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_inv.size() + q_nand.size() + q_s0.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if ((q_inv.size() + q_nand.size() + q_s0.size()) != 0) begin
            check("drain_timeout", 32'd1, 32'd0);
            q_inv.delete();
            q_nand.delete();
            q_s0.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_nand_busy", 32'(nand_busy), 32'd0);
        check("reset_nand_done", 32'(nand_done), 32'd0);
        check("reset_nand_dut_in", 32'(nand_dut_in), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Inverter with a correct inverter attached: dut_in 0 then 1, done at edge 8.
        issue(0, 1'b1, 4'd0, 5'd0, 8);
        check("inv_busy_after_start", 32'(inv_busy), 32'd1);
        check("inv_dut_in_vec0", 32'(inv_dut_in), 32'd0);
        repeat (4) @(negedge clk);
        check("inv_dut_in_vec1", 32'(inv_dut_in), 32'd1);
        drain(40);

        // NAND with dut_out tied high: only vector 3 mismatches.
        nand_mode = 1;
        issue(1, 1'b0, 4'd3, 5'd1, 16);
        drain(60);
        repeat (3) @(negedge clk);
        check("nand_done_held", 32'(nand_done), 32'd1);
        check("nand_count_held", 32'(nand_fail_count), 32'd1);

        // NAND with dut_out tied low: vectors 0..2 mismatch.
        nand_mode = 0;
        issue(1, 1'b0, 4'd0, 5'd3, 16);
        drain(60);

        // Restart with a correct NAND: results clear on the start edge.
        nand_mode = 2;
        issue(1, 1'b1, 4'd0, 5'd0, 16);
        check("restart_done_clear", 32'(nand_done), 32'd0);
        check("restart_pass_clear", 32'(nand_pass), 32'd0);
        check("restart_count_clear", 32'(nand_fail_count), 32'd0);
        check("restart_index_clear", 32'(nand_fail_index), 32'd0);
        check("restart_busy", 32'(nand_busy), 32'd1);
        drain(60);

        // Zero settle: 2 cycles per vector; a start sampled at edge 3 is ignored.
        issue(2, 1'b1, 4'd0, 5'd0, 8);
        repeat (2) @(negedge clk);
        s0_start = 1'b1;
        @(negedge clk);
        s0_start = 1'b0;
        check("s0_busy_after_ignored", 32'(s0_busy), 32'd1);
        drain(40);

        // Asynchronous reset between edges 5 and 6 of a default sweep.
        drive_start(1);
        repeat (5) @(negedge clk);
        check("mid_sweep_busy", 32'(nand_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(nand_busy), 32'd0);
        check("async_rst_dut_in", 32'(nand_dut_in), 32'd0);
        check("async_rst_count", 32'(nand_fail_count), 32'd0);
        check("async_rst_done", 32'(nand_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_idle_busy", 32'(nand_busy), 32'd0);
        check("post_rst_idle_done", 32'(nand_done), 32'd0);
        issue(1, 1'b1, 4'd0, 5'd0, 16);
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gate_truth_sweeper.md
Name: gate_truth_sweeper

Overview:
- Self-test stage for the elementary-gate library.
- Sits directly upstream of a gate under test (for example the NAND-built inverter) and drives every input combination into it.
- Consumes the gate's output after a settle delay and checks it against a parameterised truth table.
- Reports pass/fail, the first failing input vector and the failure count. Used in on-board and simulation bring-up of the gate hierarchy.

Parameters:
- N_INPUTS, 2, gate input count; legal range 1..4. Define N_VEC = 2**N_INPUTS.
- SETTLE_CYCLES, 2, wait cycles between applying a vector and sampling the output; legal range 0..15.
- EXPECTED, 4'b0111, N_VEC-bit truth table. Bit i is the expected output for input vector i. The inverter configuration is N_INPUTS=1, EXPECTED=2'b01.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- dut_in  output  N_INPUTS  vector driven to the gate under test.
- dut_out  input  1  output of the gate under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high when a sweep has completed; held until the next accepted start.
- pass  output  1  valid when done=1; high if every vector matched.
- fail_index  output  N_INPUTS  first mismatching vector index; 0 if none.
- fail_count  output  N_INPUTS+1  number of mismatching vectors; range 0..N_VEC.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. While reset is high, all state is forced immediately, without waiting for clk:
  - FSM=IDLE
  - dut_in=0, busy=0, done=0, pass=0, fail_index=0, fail_count=0
  - settle counter=0, vector index=0
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- Start acceptance:
  - In IDLE or DONE, start=1 on a rising edge (edge 0) has the following effects on that edge: clear done, pass, fail_index and fail_count; set busy=1; set vector index=0; set dut_in=0; go to DRIVE.
  - start while busy=1 is ignored.
- DRIVE (1 cycle): load settle counter with SETTLE_CYCLES. Next state is SETTLE if SETTLE_CYCLES>0, otherwise SAMPLE.
- SETTLE: decrement the counter each cycle; go to SAMPLE on the edge where the counter reaches 0. Exactly SETTLE_CYCLES cycles are spent here.
- SAMPLE (1 cycle): compare dut_out with EXPECTED[index].
  - On mismatch, increment fail_count; if fail_count was 0, capture fail_index=index.
  - If index=N_VEC-1, go to DONE. On that edge: busy=0, done=1, pass=(final fail_count==0), dut_in=0.
  - Otherwise increment index, drive dut_in=index+1, and go to DRIVE.
- dut_in is stable from the DRIVE edge through SAMPLE. It changes only on SAMPLE->DRIVE and SAMPLE->DONE edges.
- Latency: each vector takes SETTLE_CYCLES+2 cycles. done rises on edge N_VEC*(SETTLE_CYCLES+2), counted from the start-capture edge (edge 0).
- The mismatch on the final vector counts toward pass. The comparison and the DONE transition happen on the same edge.
- fail_count cannot overflow: its maximum is N_VEC, which fits in N_INPUTS+1 bits.
- The index counter does not wrap mid-sweep. The sweep ends at N_VEC-1.
- Reset asserted mid-sweep aborts the sweep with no partial results retained. After reset, the block waits for a new start.
- dut_out is sampled unsynchronised. The gate under test is combinational in the same clk domain.
- The DONE state holds all results until the next accepted start.

Test Plan:
- Inverter configuration (N_INPUTS=1, EXPECTED=2'b01, SETTLE_CYCLES=2), correct inverter attached, start pulse:
  - dut_in sequence is 0 then 1.
  - done=1 at edge 8.
  - pass=1, fail_count=0, fail_index=0, busy=0, dut_in=0.
- Default NAND configuration, dut_out tied 1:
  - vector 3 mismatches.
  - done at edge 16, pass=0, fail_count=1, fail_index=3.
- Default configuration, dut_out tied 0:
  - fail_count=3, fail_index=0, pass=0.
  - Then start again with a correct NAND attached: results clear on the start edge; final pass=1, fail_count=0.
- SETTLE_CYCLES=0 with N_INPUTS=2:
  - each vector takes 2 cycles; done at edge 8.
  - start pulsed at edge 3 is ignored: no restart, done still at edge 8.
- Reset asserted at edge 5 of a default sweep (asynchronously, between edges):
  - all outputs 0 immediately, before the next clk edge.
  - After release, no activity until start; a fresh sweep completes at edge 16 after the new start.
